// File: rtl/owm_slot_tx.sv
// 1-wire master slot generator: timed low pulse, mid-slot line sample, slot + recovery pacing.
// Optional OWM_LINE_CHECK_EN adds rsp_err (line still low at slot end).
module owm_slot_tx #(
  parameter int SL = 64,
  parameter int RN = 8,
  parameter int CW = $clog2(SL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic [CW-1:0] req_low,
  input  logic [CW-1:0] req_smp,
  output logic          req_rdy,
  output logic          owr_e,
  input  logic          owr_i,
  output logic          rsp_vld,
  output logic          rsp_dat
`ifdef OWM_LINE_CHECK_EN
  ,
  output logic          rsp_err
`endif
);

  localparam int RW = (RN > 1) ? $clog2(RN) : 1;

  typedef enum logic [1:0] {IDLE, SLOT, REC} state_t;

  state_t        state_q;
  logic [CW-1:0] t_q;
  logic [RW-1:0] rc_q;
  logic [CW-1:0] low_q;
  logic [CW-1:0] smp_q;
  logic          req_rdy_q;
  logic          owr_e_q;
  logic          rsp_vld_q;
  logic          rsp_dat_q;
`ifdef OWM_LINE_CHECK_EN
  logic          rsp_err_q;
`endif

  logic [CW-1:0] low_d;
  logic [CW-1:0] smp_d;
  logic [CW-1:0] t_nx;

  // Clamp at latch time so the slot counter can never run past the slot.
  assign low_d = (req_low > CW'(SL))     ? CW'(SL)     : req_low;
  assign smp_d = (req_smp > CW'(SL - 1)) ? CW'(SL - 1) : req_smp;
  assign t_nx  = t_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      rc_q      <= '0;
      low_q     <= '0;
      smp_q     <= '0;
      req_rdy_q <= 1'b1;
      owr_e_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 1'b0;
`ifdef OWM_LINE_CHECK_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      rsp_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_vld && req_rdy_q) begin
            low_q     <= low_d;
            smp_q     <= smp_d;
            t_q       <= '0;
            req_rdy_q <= 1'b0;
            owr_e_q   <= (low_d != '0);
            state_q   <= SLOT;
          end
        end
        SLOT: begin
          if (t_q == smp_q) rsp_dat_q <= owr_i;
          if (t_q == CW'(SL - 1)) begin
            t_q       <= '0;
            rc_q      <= '0;
            owr_e_q   <= 1'b0;
            rsp_vld_q <= 1'b1;
`ifdef OWM_LINE_CHECK_EN
            rsp_err_q <= ~owr_i;
`endif
            state_q   <= REC;
          end else begin
            // owr_e is registered, so decide for the cycle holding t+1.
            t_q     <= t_nx;
            owr_e_q <= (t_nx < low_q);
          end
        end
        REC: begin
          if (rc_q == RW'(RN - 1)) begin
            req_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            rc_q <= rc_q + RW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy = req_rdy_q;
  assign owr_e   = owr_e_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_dat = rsp_dat_q;
`ifdef OWM_LINE_CHECK_EN
  assign rsp_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_owm_slot_tx.sv
// Directed bench for owm_slot_tx: pull-up line model with optional forced-low window.
module tb_owm_slot_tx;
  localparam int SL = 64;
  localparam int RN = 8;
  localparam int CW = $clog2(SL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_vld = 1'b0;
  logic [CW-1:0] req_low = '0;
  logic [CW-1:0] req_smp = '0;
  logic          req_rdy;
  logic          owr_e;
  logic          owr_i;
  logic          rsp_vld;
  logic          rsp_dat;
`ifdef OWM_LINE_CHECK_EN
  logic          rsp_err;
`endif
  logic          force0 = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  // Open-drain line with pull-up; force0 models a slave holding it low.
  assign owr_i = force0 ? 1'b0 : ~owr_e;

  always #5 clk = ~clk;

  owm_slot_tx #(.SL(SL), .RN(RN)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_low (req_low),
    .req_smp (req_smp),
    .req_rdy (req_rdy),
    .owr_e   (owr_e),
    .owr_i   (owr_i),
    .rsp_vld (rsp_vld),
    .rsp_dat (rsp_dat)
`ifdef OWM_LINE_CHECK_EN
    ,
    .rsp_err (rsp_err)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_rdy();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (req_rdy) seen = 1'b1;
    end
    if (!seen) chk("rdy_timeout", 0, 1);
  endtask

  task automatic run_slot(input string tag, input int low, input int smp,
                          input int hold0, input int exp_dat);
    int owr_cnt = 0, owr_first = -1, owr_last = -1;
    int vld_cnt = 0, vld_cyc = -1, rdy_cyc = -1;
    int dat = -1, err = -1, exp_low;
    exp_low = (low > SL) ? SL : low;
    wait_rdy();
    req_low = CW'(low);
    req_smp = CW'(smp);
    req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      force0 = (c - 1 < hold0);
      @(negedge clk);
      if (owr_e) begin
        owr_cnt++;
        if (owr_first < 0) owr_first = c;
        owr_last = c;
      end
      if (rsp_vld) begin
        vld_cnt++;
        vld_cyc = c;
        dat = int'(rsp_dat);
`ifdef OWM_LINE_CHECK_EN
        err = int'(rsp_err);
`endif
      end
      if (req_rdy && rdy_cyc < 0) rdy_cyc = c;
      @(posedge clk); #1;
    end
    force0 = 1'b0;
    chk({tag, ":owr_cnt"}, owr_cnt, exp_low);
    if (exp_low > 0) begin
      chk({tag, ":owr_first"}, owr_first, 1);
      chk({tag, ":owr_last"}, owr_last, exp_low);
    end
    chk({tag, ":vld_cnt"}, vld_cnt, 1);
    chk({tag, ":vld_cyc"}, vld_cyc, 1 + SL);
    chk({tag, ":rdy_cyc"}, rdy_cyc, 1 + SL + RN);
    chk({tag, ":rsp_dat"}, dat, exp_dat);
    chk({tag, ":dat_hold"}, int'(rsp_dat), exp_dat);
`ifdef OWM_LINE_CHECK_EN
    chk({tag, ":rsp_err"}, err, ((hold0 > SL - 1) || (exp_low == SL)) ? 1 : 0);
`endif
  endtask

  initial begin
    int acc[3];
    int nacc, nvld, owr_cnt;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst:req_rdy", int'(req_rdy), 1);
    chk("rst:owr_e", int'(owr_e), 0);
    chk("rst:rsp_vld", int'(rsp_vld), 0);
    chk("rst:rsp_dat", int'(rsp_dat), 0);

    run_slot("write1",    6,   15, 0,  1);
    run_slot("read0",     1,   15, 31, 0);
    run_slot("clamp",     100, 127, 0, 0);
    run_slot("stuck",     6,   15, 64, 0);
    run_slot("zero_low",  0,   127, 63, 1);

    // Back-to-back with req_vld held high.
    wait_rdy();
    req_low = CW'(6);
    req_smp = CW'(15);
    req_vld = 1'b1;
    nacc = 0;
    nvld = 0;
    for (int n = 0; n < 160; n++) begin
      if (req_rdy) begin
        if (nacc < 3) acc[nacc] = n;
        nacc++;
      end
      if (rsp_vld) nvld++;
      @(posedge clk);
      @(negedge clk);
    end
    req_vld = 1'b0;
    chk("b2b:accepts", nacc, 3);
    chk("b2b:gap1", acc[1] - acc[0], 1 + SL + RN);
    chk("b2b:gap2", acc[2] - acc[1], 1 + SL + RN);
    chk("b2b:vld_cnt", nvld, 2);

    // Reset during slot cycle 3 of a 60-cycle low pulse.
    wait_rdy();
    req_low = CW'(60);
    req_smp = CW'(15);
    req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst:owr_before", int'(owr_e), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst:owr_e", int'(owr_e), 0);
    chk("mrst:rsp_vld", int'(rsp_vld), 0);
    chk("mrst:rsp_dat", int'(rsp_dat), 0);
    chk("mrst:req_rdy", int'(req_rdy), 1);
    nvld = 0;
    owr_cnt = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (rsp_vld) nvld++;
      if (owr_e) owr_cnt++;
    end
    chk("mrst:no_rsp", nvld, 0);
    chk("mrst:no_owr", owr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/owm_slot_tx.md
Name: owm_slot_tx

Overview:
- Transmit-side counterpart of the line input filter: generates timed 1-wire time slots on an open-drain line.
- On each accepted request it:
  - drives the line low for a programmable number of cycles;
  - releases the line;
  - samples the line at a programmable point;
  - enforces a fixed slot length and recovery time;
  - returns the sampled bit.
- Sits between the 1-wire master command logic and the pad's open-drain enable.

Parameters:
- SL, 64, slot length in clk cycles (SL >= 2).
- RN, 8, recovery length in clk cycles after the slot (RN >= 1).
- CW, $clog2(SL+1), width of timing fields and counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- req_vld  input  1  slot request valid.
- req_low  input  CW  low-drive time in cycles; 0 means no low pulse.
- req_smp  input  CW  sample point, as slot cycle index.
- req_rdy  output  1  ready to accept a request.
- owr_e  output  1  line drive-low enable (1 = pull low).
- owr_i  input  1  line level as seen from the pad.
- rsp_vld  output  1  one-cycle pulse: sampled bit valid.
- rsp_dat  output  1  sampled line level.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, counter 0, owr_e=0, rsp_vld=0, rsp_dat=0. req_rdy=1 in the first cycle after reset deasserts.
- All outputs are registered.
- States: IDLE, SLOT, REC.
- IDLE:
  - req_rdy=1.
  - Handshake: a request is accepted on the edge where req_vld&req_rdy.
  - On accept: latch low=min(req_low,SL) and smp=min(req_smp,SL-1); clear counter t; go to SLOT.
  - req_vld while req_rdy=0 is ignored; the source must hold it.
- SLOT:
  - t runs 0..SL-1, one increment per cycle. SLOT lasts exactly SL cycles; the first SLOT cycle is the cycle after accept.
  - owr_e=1 exactly in cycles with t<low, i.e. low consecutive cycles starting the cycle after accept.
  - low=0 means owr_e stays 0 for the whole slot.
  - Sampling: at the edge ending cycle t==smp, rsp_dat <= owr_i. This also applies when smp<low; the master then samples its own low.
  - At t==SL-1: clear t; go to REC.
- REC:
  - Lasts RN cycles with owr_e=0 and req_rdy=0.
  - rsp_vld=1 in the first REC cycle only.
  - rsp_dat holds its value until the next sample.
  - After the RN-th REC cycle, return to IDLE (req_rdy=1).
- Throughput: back-to-back requests give one slot per 1+SL+RN cycles.
- Widths: t is CW bits and never wraps. Clamping of low and smp is done at latch time; no overflow is possible.
- Reset mid-operation (any state): on the edge where rst=1, owr_e drops to 0, rsp_vld to 0, rsp_dat to 0, state to IDLE. A partial slot produces no response.
- owr_e never glitches: it is a register output and changes only on clk edges.

Optional Feature:
- Macro: OWM_LINE_CHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - rsp_err is valid with rsp_vld, and in that same cycle is set to the owr_i value sampled at the edge ending t==SL-1, inverted. rsp_err=1 means the line is still low at slot end, i.e. stuck low or a slave overrun.
  - rsp_err holds until the next rsp_vld or rst.
- Undefined: no rsp_err port, no extra sampling logic. Behaviour is otherwise identical.

Test Plan:
- Reset then write-1 slot: SL=64, RN=8, req_low=6, req_smp=15, owr_i = ~owr_e (pull-up line).
  - owr_e=1 for exactly 6 cycles starting the cycle after accept.
  - rsp_vld pulses 64 cycles after the first owr_e cycle, with rsp_dat=1.
  - req_rdy returns 73 cycles after accept.
- Read-0 slot: req_low=1, req_smp=15, bench holds owr_i=0 for slot cycles 0..30 → rsp_dat=0.
- Clamping: req_low=100 → owr_e high 64 cycles; req_smp=127 → sample at t=63.
- req_low=0 → owr_e never asserts; slot timing unchanged.
- Back-to-back with req_vld held high: accepts occur 73 cycles apart; rsp_vld pulses exactly once per slot.
- rst asserted at slot cycle 3 of a 60-cycle low → owr_e=0 the next cycle, no rsp_vld, req_rdy=1 the cycle after rst deasserts.
  - With OWM_LINE_CHECK_EN, owr_i held 0 all slot → rsp_err=1 with rsp_vld.
